// File: rtl/fcvt_sw_issue.sv
// Issue stage for integer-to-float conversion: a 2-entry in-order request FIFO
// feeding an external combinational converter, with a registered result stage.
module fcvt_sw_issue (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_rs1,
   input  logic        in_signed,
   input  logic [2:0]  in_rm,
   input  logic [4:0]  in_tag,
   input  logic [2:0]  frm,
   input  logic        flush,
   output logic [31:0] cvt_fixed,
   output logic [2:0]  cvt_rm,
   output logic        cvt_signed,
   input  logic [31:0] cvt_float,
   input  logic        cvt_invalid,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [4:0]  out_tag,
   output logic        out_invalid,
   output logic        nv_sticky,
   input  logic        nv_clear
);

   logic [31:0] r_rs1 [2];
   logic        r_sgn [2];
   logic [2:0]  r_rm  [2];
   logic [4:0]  r_tag [2];
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [1:0]  r_count;

   logic        r_out_valid;
   logic [31:0] r_out_result;
   logic [4:0]  r_out_tag;
   logic        r_out_invalid;
   logic        r_nv_sticky;

   logic        w_empty;
   logic        w_push;
   logic        w_pop;
   logic [2:0]  w_rm_res;

   assign w_empty  = (r_count == 2'd0);
   assign in_ready = (r_count < 2'd2);
   assign w_push   = in_valid && in_ready && !flush;
   assign w_pop    = !w_empty && (!r_out_valid || out_ready) && !flush;
   // DYN is resolved here so a later frm write cannot reach queued entries
   assign w_rm_res = (in_rm == 3'b111) ? frm : in_rm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_rs1[i] <= 32'd0;
            r_sgn[i] <= 1'b0;
            r_rm[i]  <= 3'd0;
            r_tag[i] <= 5'd0;
         end
      end else if (w_push) begin
         r_rs1[r_wr_ptr] <= in_rs1;
         r_sgn[r_wr_ptr] <= in_signed;
         r_rm[r_wr_ptr]  <= w_rm_res;
         r_tag[r_wr_ptr] <= in_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign cvt_fixed  = w_empty ? 32'd0 : r_rs1[r_rd_ptr];
   assign cvt_rm     = w_empty ? 3'd0  : r_rm[r_rd_ptr];
   assign cvt_signed = w_empty ? 1'b0  : r_sgn[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid   <= 1'b0;
         r_out_result  <= 32'd0;
         r_out_tag     <= 5'd0;
         r_out_invalid <= 1'b0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_pop) begin
         r_out_valid   <= 1'b1;
         r_out_result  <= cvt_float;
         r_out_tag     <= r_tag[r_rd_ptr];
         r_out_invalid <= cvt_invalid;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // a new invalid transfer takes priority over a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_nv_sticky <= 1'b0;
      end else if (w_pop && cvt_invalid) begin
         r_nv_sticky <= 1'b1;
      end else if (nv_clear) begin
         r_nv_sticky <= 1'b0;
      end
   end

   assign out_valid   = r_out_valid;
   assign out_result  = r_out_result;
   assign out_tag     = r_out_tag;
   assign out_invalid = r_out_invalid;
   assign nv_sticky   = r_nv_sticky;

endmodule

// File: tb/tb_fcvt_sw_issue.sv
// Scoreboard bench for fcvt_sw_issue with a behavioural int-to-float converter
// attached to the cvt_* port group.
module tb_fcvt_sw_issue;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_rs1 = 32'd0;
   logic        in_signed = 1'b0;
   logic [2:0]  in_rm = 3'd0;
   logic [4:0]  in_tag = 5'd0;
   logic [2:0]  frm = 3'd0;
   logic        flush = 1'b0;
   logic [31:0] cvt_fixed;
   logic [2:0]  cvt_rm;
   logic        cvt_signed;
   logic [31:0] cvt_float;
   logic        cvt_invalid;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic [4:0]  out_tag;
   logic        out_invalid;
   logic        nv_sticky;
   logic        nv_clear = 1'b0;

   always #5 clk = ~clk;

   fcvt_sw_issue dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_signed(in_signed), .in_rm(in_rm), .in_tag(in_tag),
      .frm(frm), .flush(flush), .cvt_fixed(cvt_fixed), .cvt_rm(cvt_rm),
      .cvt_signed(cvt_signed), .cvt_float(cvt_float), .cvt_invalid(cvt_invalid),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_tag(out_tag), .out_invalid(out_invalid), .nv_sticky(nv_sticky),
      .nv_clear(nv_clear)
   );

   // int32/uint32 -> float32 with RNE/RTZ/RDN/RUP/RMM; rm 5..7 is invalid
   function automatic logic [32:0] f_cvt(logic [31:0] x, logic sg, logic [2:0] rm);
      logic        neg;
      logic [63:0] mag, kept, rem, half;
      int          p, sh;
      logic        up;
      if (rm > 3'd4) return {1'b1, 32'h0};
      neg = sg && x[31];
      mag = neg ? {32'h0, (~x + 32'd1)} : {32'h0, x};
      if (mag == 64'd0) return 33'h0;
      p = 0;
      for (int i = 0; i < 33; i++) if (mag[i]) p = i;
      if (p <= 23) begin
         kept = mag << (23 - p);
      end else begin
         sh   = p - 23;
         kept = mag >> sh;
         rem  = mag & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         case (rm)
            3'd0:    up = (rem > half) || ((rem == half) && kept[0]);
            3'd2:    up = neg && (rem != 0);
            3'd3:    up = !neg && (rem != 0);
            3'd4:    up = (rem >= half);
            default: up = 1'b0;
         endcase
         if (up) kept = kept + 64'd1;
         if (kept == (64'd1 << 24)) begin
            kept = kept >> 1;
            p = p + 1;
         end
      end
      return {1'b0, neg, 8'(p + 127), kept[22:0]};
   endfunction

   logic [32:0] cvt_out;
   always_comb cvt_out = f_cvt(cvt_fixed, cvt_signed, cvt_rm);
   assign cvt_float   = cvt_out[31:0];
   assign cvt_invalid = cvt_out[32];

   typedef struct {
      logic [31:0] res;
      logic [4:0]  tag;
      logic        inv;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_out   = 0;
   bit   flushed = 1'b0;
   bit   rnd_on  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic push(input logic [31:0] rs1, input logic sg, input logic [2:0] rm,
                       input logic [4:0] tag);
      logic [2:0]  rr;
      logic [32:0] c;
      exp_t        e;
      int          budget;
      in_valid = 1'b1; in_rs1 = rs1; in_signed = sg; in_rm = rm; in_tag = tag;
      budget = 0;
      @(negedge clk);
      while (!in_ready && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (!in_ready) begin
         n_tests++; n_fail++;
         $display("FAIL push_timeout: in_ready 0 for tag %0d, expected 1", tag);
         in_valid = 1'b0;
         return;
      end
      rr = (rm == 3'b111) ? frm : rm;
      c  = f_cvt(rs1, sg, rr);
      e.res = c[31:0]; e.inv = c[32]; e.tag = tag;
      exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // monitor: pops expected on every handshake, checks hold while stalled
   initial begin
      logic        pv, pr;
      logic [31:0] pres;
      logic [4:0]  ptag;
      exp_t        e;
      pv = 1'b0; pr = 1'b0; pres = 32'd0; ptag = 5'd0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pv = 1'b0;
            continue;
         end
         if (pv && !pr && !flushed) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_result", out_result, pres);
            chk("hold_tag", out_tag, ptag);
         end
         flushed = 1'b0;
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_result: got tag %0d, expected no result", out_tag);
            end else begin
               e = exp_q.pop_front();
               chk("result", out_result, e.res);
               chk("tag", out_tag, e.tag);
               chk("invalid", out_invalid, e.inv);
            end
         end
         pv = out_valid; pr = out_ready; pres = out_result; ptag = out_tag;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, budget;
      logic [2:0] rm_sel;
      logic [31:0] rs;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_result", out_result, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rel_in_ready", in_ready, 1);
      chk("rel_out_valid", out_valid, 0);
      chk("rel_nv_sticky", nv_sticky, 0);
      chk("rel_cvt_fixed", cvt_fixed, 0);

      // minimum latency, signed -1
      out_ready = 1'b1;
      push(32'hFFFF_FFFF, 1'b1, 3'b000, 5'd3);
      chk("lat_not_early", out_valid, 0);
      @(posedge clk); #1;
      chk("neg1_valid", out_valid, 1);
      chk("neg1_result", out_result, 32'hBF80_0000);
      chk("neg1_tag", out_tag, 3);
      chk("neg1_invalid", out_invalid, 0);
      @(posedge clk); #1;

      // DYN resolved at acceptance, later frm change ignored
      frm = 3'b011;
      push(32'h0100_0001, 1'b0, 3'b111, 5'd5);
      frm = 3'b000;
      chk("dyn_cvt_rm", cvt_rm, 3);
      @(posedge clk); #1;
      chk("dyn_result", out_result, 32'h4B80_0001);
      @(posedge clk); #1;

      // backpressure and ordering
      out_ready = 1'b0;
      n0 = n_out;
      push(32'd1, 1'b0, 3'b000, 5'd1);
      push(32'd2, 1'b0, 3'b000, 5'd2);
      push(32'd3, 1'b0, 3'b000, 5'd3);
      chk("full_in_ready", in_ready, 0);
      in_valid = 1'b1; in_rs1 = 32'd4; in_signed = 1'b0; in_rm = 3'b000; in_tag = 5'd4;
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready", in_ready, 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      push(32'd4, 1'b0, 3'b000, 5'd4);
      repeat (6) @(posedge clk);
      #1;
      chk("order_count", n_out - n0, 4);

      // invalid flag and sticky
      push(32'd100, 1'b1, 3'b101, 5'd7);
      @(posedge clk); #1;
      chk("nv_out_invalid", out_invalid, 1);
      chk("nv_set", nv_sticky, 1);
      push(32'd5, 1'b0, 3'b000, 5'd8);
      push(32'd6, 1'b0, 3'b001, 5'd9);
      repeat (3) @(posedge clk);
      #1;
      chk("nv_stays", nv_sticky, 1);
      nv_clear = 1'b1;
      @(posedge clk); #1;
      nv_clear = 1'b0;
      chk("nv_cleared", nv_sticky, 0);
      push(32'd7, 1'b0, 3'b110, 5'd10);
      nv_clear = 1'b1;
      @(posedge clk); #1;
      nv_clear = 1'b0;
      chk("nv_set_wins", nv_sticky, 1);
      nv_clear = 1'b1;
      @(posedge clk); #1;
      nv_clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // flush with two queued, one held, and a same-cycle request
      out_ready = 1'b0;
      push(32'd10, 1'b0, 3'b101, 5'd10);
      push(32'd11, 1'b0, 3'b000, 5'd11);
      push(32'd12, 1'b0, 3'b000, 5'd12);
      chk("pre_flush_valid", out_valid, 1);
      chk("pre_flush_full", in_ready, 0);
      in_valid = 1'b1; in_rs1 = 32'h1234; in_rm = 3'b000; in_tag = 5'd13;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      flushed = 1'b1;
      chk("flush_in_ready", in_ready, 1);
      chk("flush_out_valid", out_valid, 0);
      chk("flush_cvt_fixed", cvt_fixed, 0);
      chk("flush_nv_kept", nv_sticky, 1);
      out_ready = 1'b1;
      n0 = n_out;
      repeat (5) @(posedge clk);
      #1;
      chk("flush_no_output", n_out - n0, 0);
      nv_clear = 1'b1;
      @(posedge clk); #1;
      nv_clear = 1'b0;

      // asynchronous reset mid-operation
      out_ready = 1'b0;
      push(32'd20, 1'b1, 3'b000, 5'd20);
      push(32'd21, 1'b1, 3'b000, 5'd21);
      push(32'd22, 1'b1, 3'b000, 5'd22);
      #2;
      rst_n = 1'b0;
      flushed = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_cvt_fixed", cvt_fixed, 0);
      chk("arst_out_tag", out_tag, 0);
      exp_q.delete();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // randomized traffic with random backpressure and frm
      rnd_on = 1'b1;
      fork
         while (rnd_on) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            frm = 3'($urandom_range(0, 7));
         end
      join_none
      for (int k = 0; k < 300; k++) begin
         case ($urandom_range(0, 3))
            0:       rs = $urandom_range(0, 300);
            1:       rs = 32'h0100_0000 | 32'($urandom_range(0, 255));
            default: rs = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0, 1:    rm_sel = 3'b111;
            2:       rm_sel = 3'b101;
            default: rm_sel = 3'($urandom_range(0, 4));
         endcase
         push(rs, 1'($urandom_range(0, 1)), rm_sel, 5'($urandom_range(0, 31)));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      rnd_on = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      out_ready = 1'b1;
      budget = 0;
      while (exp_q.size() != 0 && budget < 500) begin
         @(posedge clk);
         budget++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("drain_empty", exp_q.size(), 0);
      chk("drain_out_valid", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fcvt_sw_issue.md
FCVT_SW_ISSUE -- requirements
Module: fcvt_sw_issue

Interface
REQ-001 SHALL have exactly one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Ports, in order name, direction, width, meaning:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  conversion request valid
- in_ready  out  1  request accepted when in_valid&&in_ready at a rising edge
- in_rs1  in  32  Q32.0 integer operand
- in_signed  in  1  1=fcvt.s.w, 0=fcvt.s.wu
- in_rm  in  3  instruction rm field; 3'b111=DYN
- in_tag  in  5  destination tag, returned unchanged
- frm  in  3  CSR dynamic rounding mode
- flush  in  1  synchronous pipeline kill
- cvt_fixed  out  32  to converter fixedq32
- cvt_rm  out  3  to converter rm
- cvt_signed  out  1  to converter is_signed
- cvt_float  in  32  from converter float32 (combinational)
- cvt_invalid  in  1  from converter f32_invalid
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_result  out  32  IEEE-754 single result
- out_tag  out  5  tag of out_result
- out_invalid  out  1  invalid flag of out_result
- nv_sticky  out  1  accumulated invalid flag
- nv_clear  in  1  synchronous clear of nv_sticky

Function
REQ-003 SHALL hold requests in a 2-entry in-order FIFO; each entry = {rs1, signed, resolved rm, tag}.
REQ-004 Resolved rm SHALL be computed at acceptance: in_rm if in_rm!=3'b111, else frm sampled in the acceptance cycle; later frm changes SHALL NOT affect queued entries.
REQ-005 in_ready SHALL equal (FIFO count<2); no same-cycle push-when-full bypass.
REQ-006 cvt_fixed/cvt_rm/cvt_signed SHALL present the FIFO head whenever count>0, and SHALL be 0 when empty.
REQ-007 Transfer: when count>0 and (!out_valid || out_ready), at the edge pop the head and load out_result=cvt_float, out_invalid=cvt_invalid, out_tag=head tag, out_valid=1.
REQ-008 When out_valid && out_ready and no transfer, out_valid SHALL clear; out_* SHALL hold stable while out_valid && !out_ready.
REQ-009 Simultaneous push and pop SHALL leave count unchanged; count SHALL never exceed 2 nor underflow.
REQ-010 Latency: request accepted at edge N appears with out_valid=1 after edge N+1 (minimum); throughput 1 per cycle with out_ready=1.
REQ-011 Results SHALL leave in acceptance order.
REQ-012 nv_sticky SHALL set on every transfer with cvt_invalid=1; nv_clear SHALL clear it; set wins over clear in the same cycle.
REQ-013 flush SHALL at the edge empty the FIFO and clear out_valid; a push in the flush cycle SHALL be discarded; nv_sticky SHALL be unaffected.

Reset
REQ-014 While rst_n=0: count=0, out_valid=0, out_result=0, out_tag=0, out_invalid=0, nv_sticky=0, in_ready=1 (combinational from count), cvt_* =0.
REQ-015 Reset assertion mid-operation SHALL drop all queued and held results immediately, without a clock.

Verification (bench instantiates the real converter on cvt_*)
REQ-016 Reset release -> in_ready=1, out_valid=0, nv_sticky=0, cvt_fixed=0.
REQ-017 Push rs1=32'hFFFFFFFF, signed=1, rm=000, tag=3, out_ready=1 -> out_result=32'hBF800000, out_tag=3, out_invalid=0 after edge N+1.
REQ-018 Push rs1=32'h01000001, signed=0, in_rm=111, frm=011, then frm=000 next cycle -> out_result=32'h4B800001 (RUP retained).
REQ-019 out_ready=0, push tags 1,2,3,4 back-to-back -> in_ready low after tag 3 accepted, tag 4 held; then out_ready=1 -> tags 1,2,3,4 emerge in order, none lost or duplicated.
REQ-020 Push in_rm=101 -> out_invalid=1, nv_sticky=1 and stays 1 after subsequent valid ops; pulse nv_clear -> nv_sticky=0.
REQ-021 Two entries queued, out_valid=1, out_ready=0, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, no result for the flushed or same-cycle request.
